cordic_fixedpoint_get_phase_rom_c_loader: RTL

Run-time writer for the 16-entry threshold table C that the phase-address comparator stage compares |z| against. Accepts 21-bit thresholds one at a time over a valid/ready stream after a start pulse. Stores them in a register file. Presents the whole table as a flattened bus with a table-valid qualifier. Sits between the host/config port and the get_phase_addr compare logic, replacing the static file-initialised table.

---
 rtl/cordic_fixedpoint_pkg.sv | 24 ++
 rtl/cordic_fixedpoint_rom_C_mono_chk.sv | 19 +
 rtl/cordic_fixedpoint_get_phase_rom_c_loader.sv | 107 ++++++++++
 3 files changed

// File: rtl/cordic_fixedpoint_pkg.sv
// cordic_fixedpoint_pkg: shared constants for the threshold-table loader,
// the loader state encoding and a helper that slices one entry out of the
// flattened table bus.
package cordic_fixedpoint_pkg;

  localparam int ROM_C_W   = 21;
  localparam int ROM_C_N   = 16;
  localparam int ROM_PTR_W = $clog2(ROM_C_N);

  typedef enum logic [1:0] {
    stIdle = 2'd0,
    stLoad = 2'd1,
    stDone = 2'd2
  } loaderStateE;

  // Entry k of the flattened table lives at bits [k*ROM_C_W +: ROM_C_W].
  function automatic logic [ROM_C_W-1:0] tableEntry(
    input logic [ROM_C_N*ROM_C_W-1:0] tbl,
    input int                         k
  );
    return tbl[k*ROM_C_W +: ROM_C_W];
  endfunction

endpackage

// File: rtl/cordic_fixedpoint_rom_C_mono_chk.sv
// cordic_fixedpoint_rom_C_mono_chk: flags a threshold that does not strictly
// exceed the previously written entry. The first entry (ptr==0) has no
// predecessor and is never flagged.
module cordic_fixedpoint_rom_C_mono_chk
  import cordic_fixedpoint_pkg::*;
#(
  parameter int C_W   = ROM_C_W,
  parameter int PTR_W = ROM_PTR_W
) (
  input  logic [C_W-1:0]   iData,
  input  logic [C_W-1:0]   iPrev,
  input  logic [PTR_W-1:0] iPtr,
  output logic             oErrNxt
);

  // Combinational ordering test for the beat being transferred.
  assign oErrNxt = (iPtr != '0) && (iData <= iPrev);

endmodule

// File: rtl/cordic_fixedpoint_get_phase_rom_c_loader.sv
// cordic_fixedpoint_get_phase_rom_c_loader: run-time writer for the 16-entry
// threshold table used by the phase-address comparator.
// Optional build macro: CORDIC_ROM_C_MONO_CHECK_EN enables the strictly
// ascending order check; without it oLoad_err stays 0 and DONE always
// qualifies the table.
//
// state | meaning
// IDLE  | no load in progress, table not yet qualified since reset/start
// LOAD  | accepting one threshold per beat, ptr = next entry to write
// DONE  | all entries written, table valid unless an ordering error occurred
module cordic_fixedpoint_get_phase_rom_c_loader
  import cordic_fixedpoint_pkg::*;
#(
  parameter int C_W = ROM_C_W,
  parameter int C_N = ROM_C_N
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic             iData_valid,
  input  logic [C_W-1:0]   iData,
  output logic             oData_ready,
  output logic [C_N*C_W-1:0] oTable,
  output logic             oTable_valid,
  output logic             oBusy,
  output logic             oLoad_err
);

  localparam int PTR_W = $clog2(C_N);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(C_N - 1);

  localparam logic [1:0] IDLE = stIdle;
  localparam logic [1:0] LOAD = stLoad;
  localparam logic [1:0] DONE = stDone;

  logic [1:0]       state;
  logic [PTR_W-1:0] ptr;
  logic [C_W-1:0]   regFile [C_N];
  logic             tableValid;
  logic             loadErr;
  logic             errNxt;

`ifdef CORDIC_ROM_C_MONO_CHECK_EN
  logic [PTR_W-1:0] prevIdx;
  assign prevIdx = ptr - 1'b1;

  cordic_fixedpoint_rom_C_mono_chk #(
    .C_W   (C_W),
    .PTR_W (PTR_W)
  ) uMonoChk (
    .iData   (iData),
    .iPrev   (regFile[prevIdx]),
    .iPtr    (ptr),
    .oErrNxt (errNxt)
  );
`else
  assign errNxt = 1'b0;
`endif

  // Sequencer and register file; iStart always wins over a same-cycle beat.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state      <= IDLE;
      ptr        <= '0;
      tableValid <= 1'b0;
      loadErr    <= 1'b0;
      for (int k = 0; k < C_N; k++) regFile[k] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (iStart) begin
            state      <= LOAD;
            ptr        <= '0;
            tableValid <= 1'b0;
            loadErr    <= 1'b0;
          end
        end
        LOAD: begin
          if (iStart) begin
            ptr     <= '0;
            loadErr <= 1'b0;
          end else if (iData_valid) begin
            regFile[ptr] <= iData;
            ptr          <= ptr + 1'b1;
            if (errNxt) loadErr <= 1'b1;
            if (ptr == LAST_PTR) begin
              state      <= DONE;
              tableValid <= !(loadErr || errNxt);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Flatten the register file straight onto the table bus.
  for (genvar k = 0; k < C_N; k++) begin : gTable
    assign oTable[k*C_W +: C_W] = regFile[k];
  end

  assign oData_ready  = (state == LOAD);
  assign oBusy        = (state == LOAD);
  assign oTable_valid = tableValid;
  assign oLoad_err    = loadErr;

endmodule
